// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared floating-point definitions for the fp64 -> fp32 rounding stage:
// IEEE-754 field widths, exponent biases, special fp32 encodings, the operand
// class enum and the packed payloads carried between pipeline stages.
// -----------------------------------------------------------------------------
package fp_pkg;

    localparam int FP64_EXP_W  = 11;
    localparam int FP64_MANT_W = 52;
    localparam int FP32_EXP_W  = 8;
    localparam int FP32_MANT_W = 23;

    localparam int EXP_BIAS64 = 1023;
    localparam int EXP_BIAS32 = 127;

    // Rebias fp64 -> fp32 exponent; kept as signed 12-bit so e_d - 896 never wraps.
    localparam logic signed [11:0] BIAS_DIFF = 12'(EXP_BIAS64 - EXP_BIAS32);

    // Number of fp64 mantissa bits dropped when narrowing to fp32.
    localparam int ROUND_BITS = FP64_MANT_W - FP32_MANT_W;

    localparam logic [FP64_EXP_W-1:0] FP64_EXP_MAX = 11'h7FF;
    localparam logic [31:0]           FP32_INF     = 32'h7F800000;
    localparam logic [31:0]           FP32_QNAN    = 32'h7FC00000;

    typedef enum logic [1:0] {
        CLASS_ZERO = 2'd0,
        CLASS_NORM = 2'd1,
        CLASS_INF  = 2'd2,
        CLASS_NAN  = 2'd3
    } fpClass_e;

    // Stage 1 -> stage 2 payload: classification plus the rounding decision.
    typedef struct packed {
        logic                    sign;
        fpClass_e                cls;
        logic signed [11:0]      expS;
        logic [FP32_MANT_W-1:0]  keep;
        logic                    inc;
        logic                    inexact;   // zero class: nonzero subnormal flushed
    } stage1_t;

    // Stage 2 output payload: packed fp32 result and exception flags.
    typedef struct packed {
        logic [31:0] result;
        logic        ovf;
        logic        unf;
        logic        inexact;
    } stage2_t;

endpackage

// File: rtl/fp_pipe_reg.sv
// -----------------------------------------------------------------------------
// fp_pipe_reg
// Enable-gated pipeline register with a companion valid bit. Both valid and
// data load together when en is high and hold otherwise.
// Ports:
//   clk      in   clock (rising edge)
//   rst      in   asynchronous active-high reset, clears valid and data
//   en       in   load enable (global pipeline advance)
//   validIn  in   valid bit for dataIn
//   dataIn   in   WIDTH-bit payload
//   validOut out  registered valid
//   dataOut  out  registered payload
// -----------------------------------------------------------------------------
module fp_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             validIn,
    input  logic [WIDTH-1:0] dataIn,
    output logic             validOut,
    output logic [WIDTH-1:0] dataOut
);

    // Stage register: advance on enable, hold while the pipeline is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validOut <= 1'b0;
            dataOut  <= {WIDTH{1'b0}};
        end else if (en) begin
            validOut <= validIn;
            dataOut  <= dataIn;
        end
    end

endmodule

// File: rtl/fp64_to_fp32_rounder.sv
// -----------------------------------------------------------------------------
// fp64_to_fp32_rounder
// Narrows an fp64 product stream to IEEE-754 single precision with exception
// flags. Two-stage pipeline (classify/round-decide, then apply/pack) with a
// valid/ready handshake on both sides; one result per cycle when unstalled.
// Ports:
//   clk         in   clock
//   rst         in   asynchronous active-high reset
//   din[63:0]   in   fp64 operand {sign, exp[10:0], mant[51:0]}
//   din_valid   in   operand valid
//   din_ready   out  operand accepted this cycle (combinational)
//   dout[31:0]  out  fp32 result {sign, exp[7:0], mant[22:0]}
//   dout_valid  out  result and flags valid
//   dout_ready  in   consumer takes the result this cycle
//   ovf         out  overflow to +/-inf
//   unf         out  nonzero input flushed to +/-0
//   inexact     out  discarded bits nonzero, or ovf/unf
// Parameters:
//   ROUND_MODE  0 = round-to-nearest-even, 1 = truncate
//   CANON_NAN   result for any NaN input (sign forced to 0)
// -----------------------------------------------------------------------------
module fp64_to_fp32_rounder
    import fp_pkg::*;
#(
    parameter int          ROUND_MODE = 0,
    parameter logic [31:0] CANON_NAN  = FP32_QNAN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [31:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        ovf,
    output logic        unf,
    output logic        inexact
);

    logic                    en_s;
    logic [FP64_EXP_W-1:0]   expD_s;
    logic [FP64_MANT_W-1:0]  mant_s;
    logic                    guard_s;
    logic                    sticky_s;
    stage1_t                 s1Next_s;
    stage1_t                 s1_r;
    logic                    s1Valid_r;
    logic [FP32_MANT_W:0]    sum_s;
    logic [FP32_MANT_W-1:0]  mantOut_s;
    logic signed [11:0]      expAdj_s;
    stage2_t                 s2Next_s;
    stage2_t                 s2_r;
    logic                    s2Valid_r;

    // A single enable moves the whole pipeline; an empty or draining output frees it.
    assign en_s      = !s2Valid_r || dout_ready;
    assign din_ready = en_s;

    assign expD_s   = din[62:52];
    assign mant_s   = din[FP64_MANT_W-1:0];
    assign guard_s  = mant_s[ROUND_BITS-1];
    assign sticky_s = |mant_s[ROUND_BITS-2:0];

    // Stage 1: classify the operand and decide whether to round up.
    always_comb begin
        s1Next_s.sign = din[63];
        s1Next_s.expS = $signed({1'b0, expD_s}) - BIAS_DIFF;
        s1Next_s.keep = mant_s[FP64_MANT_W-1 -: FP32_MANT_W];
        if (ROUND_MODE == 32'sd0) begin
            s1Next_s.inc = guard_s && (sticky_s || mant_s[ROUND_BITS]);
        end else begin
            s1Next_s.inc = 1'b0;
        end
        if (expD_s == 11'd0) begin
            // fp64 subnormals are flushed; flag only if something was lost.
            s1Next_s.cls     = CLASS_ZERO;
            s1Next_s.inexact = |mant_s;
        end else if (expD_s == FP64_EXP_MAX) begin
            s1Next_s.cls     = (|mant_s) ? CLASS_NAN : CLASS_INF;
            s1Next_s.inexact = 1'b0;
        end else begin
            s1Next_s.cls     = CLASS_NORM;
            s1Next_s.inexact = guard_s || sticky_s;
        end
    end

    fp_pipe_reg #(
        .WIDTH ($bits(stage1_t))
    ) stage1Reg (
        .clk      (clk),
        .rst      (rst),
        .en       (en_s),
        .validIn  (din_valid),
        .dataIn   (s1Next_s),
        .validOut (s1Valid_r),
        .dataOut  (s1_r)
    );

    // Mantissa increment; a carry out of 23 bits renormalises into the exponent.
    always_comb begin
        sum_s = {1'b0, s1_r.keep} + {{FP32_MANT_W{1'b0}}, s1_r.inc};
        if (sum_s[FP32_MANT_W]) begin
            mantOut_s = {FP32_MANT_W{1'b0}};
            expAdj_s  = s1_r.expS + 12'sd1;
        end else begin
            mantOut_s = sum_s[FP32_MANT_W-1:0];
            expAdj_s  = s1_r.expS;
        end
    end

    // Stage 2: range-check the rounded exponent and pack result plus flags.
    always_comb begin
        s2Next_s.result  = 32'd0;
        s2Next_s.ovf     = 1'b0;
        s2Next_s.unf     = 1'b0;
        s2Next_s.inexact = 1'b0;
        case (s1_r.cls)
            CLASS_ZERO: begin
                s2Next_s.result  = {s1_r.sign, 31'd0};
                s2Next_s.unf     = s1_r.inexact;
                s2Next_s.inexact = s1_r.inexact;
            end
            CLASS_INF: begin
                s2Next_s.result = {s1_r.sign, FP32_INF[30:0]};
            end
            CLASS_NAN: begin
                s2Next_s.result = {1'b0, CANON_NAN[30:0]};
            end
            CLASS_NORM: begin
                if (expAdj_s >= 12'sd255) begin
                    // Overflow saturates to infinity even when truncating.
                    s2Next_s.result  = {s1_r.sign, FP32_INF[30:0]};
                    s2Next_s.ovf     = 1'b1;
                    s2Next_s.inexact = 1'b1;
                end else if (expAdj_s <= 12'sd0) begin
                    // No fp32 subnormals are produced; flush to signed zero.
                    s2Next_s.result  = {s1_r.sign, 31'd0};
                    s2Next_s.unf     = 1'b1;
                    s2Next_s.inexact = 1'b1;
                end else begin
                    s2Next_s.result  = {s1_r.sign, expAdj_s[FP32_EXP_W-1:0], mantOut_s};
                    s2Next_s.inexact = s1_r.inexact;
                end
            end
            default: begin
                s2Next_s.result = 32'd0;
            end
        endcase
    end

    fp_pipe_reg #(
        .WIDTH ($bits(stage2_t))
    ) stage2Reg (
        .clk      (clk),
        .rst      (rst),
        .en       (en_s),
        .validIn  (s1Valid_r),
        .dataIn   (s2Next_s),
        .validOut (s2Valid_r),
        .dataOut  (s2_r)
    );

    assign dout       = s2_r.result;
    assign ovf        = s2_r.ovf;
    assign unf        = s2_r.unf;
    assign inexact    = s2_r.inexact;
    assign dout_valid = s2Valid_r;

endmodule

// File: tb/tb_fp64_to_fp32_rounder.sv
// -----------------------------------------------------------------------------
// tb_fp64_to_fp32_rounder
// Scoreboard bench: two instances (round-to-nearest-even and truncate) share
// the input stream and output handshake. Each accepted operand pushes its
// hand-computed results; a monitor pops and compares whenever a result leaves.
// -----------------------------------------------------------------------------
module tb_fp64_to_fp32_rounder;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] din;
    logic        din_valid;
    logic        dout_ready;
    logic        din_ready, dout_valid, ovf, unf, inexact;
    logic [31:0] dout;
    logic        dinReady2, doutValid2, ovf2, unf2, inexact2;
    logic [31:0] dout2;

    fp64_to_fp32_rounder #(.ROUND_MODE(0)) dutRne (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .ovf(ovf), .unf(unf), .inexact(inexact)
    );

    fp64_to_fp32_rounder #(.ROUND_MODE(1)) dutTrz (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(dinReady2),
        .dout(dout2), .dout_valid(doutValid2), .dout_ready(dout_ready),
        .ovf(ovf2), .unf(unf2), .inexact(inexact2)
    );

    always #5 clk = ~clk;

    // Flags are {ovf, unf, inexact}.
    typedef struct packed {
        logic [63:0] din;
        logic [31:0] rneRes;
        logic [2:0]  rneFlg;
        logic [31:0] trzRes;
        logic [2:0]  trzFlg;
    } vec_t;

    localparam int NVEC = 14;
    vec_t        vecs [NVEC];
    logic [34:0] qRne [$];
    logic [34:0] qTrz [$];
    int          nChecks = 0;
    int          nFails  = 0;
    logic [34:0] expRne, expTrz, held;
    bit          heldValid = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic failNow(input string name);
        nChecks++;
        nFails++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Present an operand (called just after a rising edge) and hold it until accepted.
    task automatic sendOp(input int idx);
        int waited = 0;
        din       = vecs[idx].din;
        din_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (din_ready) begin
                qRne.push_back({vecs[idx].rneRes, vecs[idx].rneFlg});
                qTrz.push_back({vecs[idx].trzRes, vecs[idx].trzFlg});
                break;
            end
            waited++;
            if (waited > 50) begin
                failNow("accept_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Called right after an accepting edge with nothing else queued behind it.
    task automatic latencyCheck(input string name);
        @(negedge clk);
        check({name, "_stage1_only"}, 64'(dout_valid), 64'd0);
        @(negedge clk);
        check({name, "_out_valid"}, 64'(dout_valid), 64'd1);
    endtask

    task automatic drain();
        int t = 0;
        while ((qRne.size() != 0 || qTrz.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) failNow("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare each departing result, and check hold behaviour under stall.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst) begin
                heldValid = 1'b0;
            end else begin
                if (dout_valid && dout_ready) begin
                    if (qRne.size() == 0) begin
                        failNow("rne_unexpected_output");
                    end else begin
                        expRne = qRne.pop_front();
                        check("rne_result", 64'(dout), 64'(expRne[34:3]));
                        check("rne_flags", 64'({ovf, unf, inexact}), 64'(expRne[2:0]));
                    end
                end
                if (doutValid2 && dout_ready) begin
                    if (qTrz.size() == 0) begin
                        failNow("trz_unexpected_output");
                    end else begin
                        expTrz = qTrz.pop_front();
                        check("trz_result", 64'(dout2), 64'(expTrz[34:3]));
                        check("trz_flags", 64'({ovf2, unf2, inexact2}), 64'(expTrz[2:0]));
                    end
                end
                if (dout_valid && !dout_ready) begin
                    check("stall_din_ready", 64'(din_ready), 64'd0);
                    if (heldValid) begin
                        check("stall_hold", 64'({dout, ovf, unf, inexact}), 64'(held));
                    end
                    held      = {dout, ovf, unf, inexact};
                    heldValid = 1'b1;
                end else begin
                    heldValid = 1'b0;
                end
            end
        end
    end

    initial begin : stimulus
        vecs[0]  = '{64'h3FF8000000000000, 32'h3FC00000, 3'b000, 32'h3FC00000, 3'b000};
        vecs[1]  = '{64'h3FF0000010000000, 32'h3F800000, 3'b001, 32'h3F800000, 3'b001};
        vecs[2]  = '{64'h3FF0000030000000, 32'h3F800002, 3'b001, 32'h3F800001, 3'b001};
        vecs[3]  = '{64'h3FFFFFFFF0000000, 32'h40000000, 3'b001, 32'h3FFFFFFF, 3'b001};
        vecs[4]  = '{64'h47F0000000000000, 32'h7F800000, 3'b101, 32'h7F800000, 3'b101};
        vecs[5]  = '{64'h3800000000000000, 32'h00000000, 3'b011, 32'h00000000, 3'b011};
        vecs[6]  = '{64'h8000000000000000, 32'h80000000, 3'b000, 32'h80000000, 3'b000};
        vecs[7]  = '{64'h7FF8000000000001, 32'h7FC00000, 3'b000, 32'h7FC00000, 3'b000};
        vecs[8]  = '{64'hC000000000000000, 32'hC0000000, 3'b000, 32'hC0000000, 3'b000};
        vecs[9]  = '{64'hFFF0000000000000, 32'hFF800000, 3'b000, 32'hFF800000, 3'b000};
        vecs[10] = '{64'h0000000000000001, 32'h00000000, 3'b011, 32'h00000000, 3'b011};
        vecs[11] = '{64'h3810000000000000, 32'h00800000, 3'b000, 32'h00800000, 3'b000};
        vecs[12] = '{64'h47EFFFFFE0000000, 32'h7F7FFFFF, 3'b000, 32'h7F7FFFFF, 3'b000};
        vecs[13] = '{64'h47EFFFFFF0000000, 32'h7F800000, 3'b101, 32'h7F7FFFFF, 3'b001};

        rst        = 1'b1;
        din        = 64'd0;
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_dout", 64'(dout), 64'd0);
        check("reset_dout_valid", 64'(dout_valid), 64'd0);
        check("reset_flags", 64'({ovf, unf, inexact}), 64'd0);
        check("reset_trz_valid", 64'(doutValid2), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single operand: result and two-cycle latency.
        sendOp(0);
        din_valid = 1'b0;
        latencyCheck("t1_latency");
        drain();

        // Every vector back to back with the consumer always ready.
        for (int i = 0; i < NVEC; i++) sendOp(i);
        din_valid = 1'b0;
        drain();

        // Six-operand stream with the consumer stalling for three cycles.
        fork
            begin
                for (int i = 0; i < 6; i++) sendOp(i + 2);
                din_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                dout_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                dout_ready = 1'b1;
            end
        join
        drain();

        // Asynchronous reset with two operands in flight.
        sendOp(2);
        sendOp(3);
        din_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_dout_valid", 64'(dout_valid), 64'd0);
        check("rst_mid_trz_valid", 64'(doutValid2), 64'd0);
        check("rst_mid_dout", 64'(dout), 64'd0);
        check("rst_mid_flags", 64'({ovf, unf, inexact}), 64'd0);
        qRne.delete();
        qTrz.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        sendOp(5);
        din_valid = 1'b0;
        latencyCheck("t6_latency");
        drain();

        repeat (4) @(negedge clk);
        check("rne_queue_empty", 64'(qRne.size()), 64'd0);
        check("trz_queue_empty", 64'(qTrz.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
